// File: rtl/rst_req_ctrl.sv
// Reset-request sequencer for a downstream reset synchronizer / clock-gate stage.
// Latency: req_i rise -> clk_en_o low 1 cycle later; ack_o after 1+GATE+HOLD+RELEASE cycles.
// Backpressure: 4-phase req/ack handshake; a new sequence needs req_i low observed in IDLE.
//
// Ports:
//   clk_i      always-on clock
//   rstn_i     asynchronous active-low reset
//   req_i      level reset request (4-phase handshake), synchronous to clk_i
//   ack_o      sequence complete; held until req_i falls
//   busy_o     high in GATE, ASSERT and RELEASE
//   clk_en_o   functional clock enable to the downstream clock gate
//   rstn_o     active-low reset to the downstream synchronizer (rstn_q & rstn_i)
//   seq_cnt_o  saturating completed-sequence count
//
// Optional feature macro: RST_REQ_CNT_EN. When it is defined, seq_cnt_o is an 8-bit
// saturating register. When it is undefined, seq_cnt_o is tied to 0.
module rst_req_ctrl #(
  parameter int GATE_CYCLES    = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic       clk_en_o,
  output logic       rstn_o,
  output logic [7:0] seq_cnt_o
);

  localparam int MAX_GH = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_GH > RELEASE_CYCLES) ? MAX_GH : RELEASE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GATE    = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            arm_q, arm_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            clk_en_q, clk_en_d;
  logic            rstn_q, rstn_d;
  logic            done;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    arm_d   = arm_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // arm_q records that req_i was seen low here, so a request still
        // held high after an aborted sequence cannot restart one.
        if (!req_i) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          arm_d   = 1'b0;
          state_d = S_GATE;
          cnt_d   = CW'(GATE_CYCLES);
        end
      end
      S_GATE: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_ASSERT;
          cnt_d   = CW'(HOLD_CYCLES);
        end
      end
      S_ASSERT: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_RELEASE;
          cnt_d   = CW'(RELEASE_CYCLES);
        end
      end
      S_RELEASE: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_ACK;
          done    = 1'b1;
        end
      end
      S_ACK: begin
        if (!req_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so that they are registered.
    clk_en_d = (state_d == S_IDLE) || (state_d == S_ACK);
    busy_d   = (state_d == S_GATE) || (state_d == S_ASSERT) || (state_d == S_RELEASE);
    ack_d    = (state_d == S_ACK);
    rstn_d   = (state_d != S_ASSERT);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      arm_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      clk_en_q <= 1'b1;
      rstn_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      clk_en_q <= clk_en_d;
      rstn_q   <= rstn_d;
    end
  end

  assign ack_o    = ack_q;
  assign busy_o   = busy_q;
  assign clk_en_o = clk_en_q;
  // Global reset reaches the downstream stage without needing a clock edge.
  assign rstn_o   = rstn_q & rstn_i;

`ifdef RST_REQ_CNT_EN
  logic [7:0] seq_cnt_q, seq_cnt_d;

  always_comb begin
    seq_cnt_d = seq_cnt_q;
    if (done && (seq_cnt_q != 8'hFF)) begin
      seq_cnt_d = seq_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_cnt_q <= 8'd0;
    end else begin
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign seq_cnt_o = seq_cnt_q;
`else
  assign seq_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl at default parameters.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Cycle 0 is the cycle in which req_i is first presented high.
module tb_rst_req_ctrl;

  logic       clk_i;
  logic       rstn_i;
  logic       req_i;
  logic       ack_o;
  logic       busy_o;
  logic       clk_en_o;
  logic       rstn_o;
  logic [7:0] seq_cnt_o;

  int checks;
  int failures;

  rst_req_ctrl dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (req_i),
    .ack_o     (ack_o),
    .busy_o    (busy_o),
    .clk_en_o  (clk_en_o),
    .rstn_o    (rstn_o),
    .seq_cnt_o (seq_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Two idle cycles with req_i low, so the block is IDLE and armed.
  task automatic settle();
    req_i = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    req_i  = 1'b0;
    step();
    step();
    checks++;
    if (rstn_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_rstn_o got=%b exp=0", rstn_o);
    end
    checks++;
    if (clk_en_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_clk_en got=%b exp=1", clk_en_o);
    end
    checks++;
    if (ack_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack_busy got=%b%b exp=00", ack_o, busy_o);
    end
    checks++;
    if (seq_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_seq_cnt got=%0d exp=0", seq_cnt_o);
    end
    rstn_i = 1'b1;
    #1;
    checks++;
    if (rstn_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rstn_o got=%b exp=1", rstn_o);
    end
  endtask

  // Full sequence with req_i held until cycle 25; ack_o must fall at 26.
  task automatic test_sequence(input string tag);
    logic exp_clk_en, exp_rstn, exp_busy, exp_ack;
    settle();
    req_i = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      exp_clk_en = !(c >= 1 && c <= 20);
      exp_rstn   = !(c >= 5 && c <= 12);
      exp_busy   = (c >= 1 && c <= 20);
      exp_ack    = (c >= 21 && c <= 25);
      checks++;
      if (clk_en_o !== exp_clk_en || rstn_o !== exp_rstn ||
          busy_o !== exp_busy || ack_o !== exp_ack) begin
        failures++;
        $display("FAIL %s cycle=%0d got clk_en/rstn/busy/ack=%b%b%b%b exp=%b%b%b%b",
                 tag, c, clk_en_o, rstn_o, busy_o, ack_o,
                 exp_clk_en, exp_rstn, exp_busy, exp_ack);
      end
      if (c == 25) req_i = 1'b0;
    end
  endtask

  task automatic test_pulse();
    logic exp_ack, exp_busy;
    settle();
    req_i = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c == 1) req_i = 1'b0;
      exp_ack  = (c == 21);
      exp_busy = (c >= 1 && c <= 20);
      checks++;
      if (ack_o !== exp_ack || busy_o !== exp_busy) begin
        failures++;
        $display("FAIL pulse cycle=%0d got ack/busy=%b%b exp=%b%b",
                 c, ack_o, busy_o, exp_ack, exp_busy);
      end
    end
  endtask

  task automatic test_abort();
    settle();
    req_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) req_i = 1'b0;
    end
    checks++;
    if (rstn_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre cycle=8 got rstn/busy=%b%b exp=01", rstn_o, busy_o);
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if (rstn_o !== 1'b0 || clk_en_o !== 1'b1 || busy_o !== 1'b0 || ack_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got rstn/clk_en/busy/ack=%b%b%b%b exp=0100",
               rstn_o, clk_en_o, busy_o, ack_o);
    end
    step();
    step();
    rstn_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      checks++;
      if (rstn_o !== 1'b1 || clk_en_o !== 1'b1 || busy_o !== 1'b0 || ack_o !== 1'b0) begin
        failures++;
        $display("FAIL abort_after idx=%0d got rstn/clk_en/busy/ack=%b%b%b%b exp=1100",
                 c, rstn_o, clk_en_o, busy_o, ack_o);
      end
    end
  endtask

  // req_i held 10 cycles past ACK: no second sequence; then a fresh one.
  task automatic test_hold_ack();
    settle();
    req_i = 1'b1;
    for (int c = 1; c <= 21; c++) step();
    for (int c = 21; c <= 31; c++) begin
      checks++;
      if (ack_o !== 1'b1 || busy_o !== 1'b0 || clk_en_o !== 1'b1) begin
        failures++;
        $display("FAIL hold_ack cycle=%0d got ack/busy/clk_en=%b%b%b exp=101",
                 c, ack_o, busy_o, clk_en_o);
      end
      if (c < 31) step();
    end
    req_i = 1'b0;
    step();
    checks++;
    if (ack_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack_drop got ack/busy=%b%b exp=00", ack_o, busy_o);
    end
    test_sequence("second_seq");
  endtask

  task automatic one_seq();
    settle();
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    for (int c = 2; c <= 21; c++) step();
  endtask

  task automatic test_count();
`ifdef RST_REQ_CNT_EN
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    for (int n = 0; n < 3; n++) one_seq();
    checks++;
    if (seq_cnt_o !== 8'd3) begin
      failures++;
      $display("FAIL count_3 got=%0d exp=3", seq_cnt_o);
    end
    for (int n = 3; n < 300; n++) one_seq();
    checks++;
    if (seq_cnt_o !== 8'd255) begin
      failures++;
      $display("FAIL count_sat got=%0d exp=255", seq_cnt_o);
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if (seq_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL count_clear got=%0d exp=0", seq_cnt_o);
    end
    step();
    rstn_i = 1'b1;
`else
    for (int n = 0; n < 3; n++) one_seq();
    checks++;
    if (seq_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL count_tied got=%0d exp=0", seq_cnt_o);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn_i   = 1'b0;
    req_i    = 1'b0;
    test_reset();
    test_sequence("sequence");
    test_pulse();
    test_abort();
    test_hold_ack();
    test_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
